// File: rtl/code_sender_pkg.sv
// Shared definitions for the colour-code lock link: FSM encodings, symbol codes
// and the symbol-to-colour decode used by sender, detector and bench alike.
package code_sender_pkg;

    // FSM state encodings; unused codes (5..7) are treated as illegal
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_SYM   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Two-bit symbol codes carried in the Code vector
    localparam logic [1:0] SYM_NONE = 2'b00;
    localparam logic [1:0] SYM_R    = 2'b01;
    localparam logic [1:0] SYM_G    = 2'b10;
    localparam logic [1:0] SYM_B    = 2'b11;

    // Symbol to one-hot {R,G,B}; an empty slot lights nothing
    function automatic logic [2:0] sym_onehot(input logic [1:0] sym);
        logic [2:0] rgb;
        case (sym)
            SYM_R:   rgb = 3'b100;
            SYM_G:   rgb = 3'b010;
            SYM_B:   rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/code_sym_decode.sv
// Combinational 2-bit symbol to {R,G,B} one-hot decoder.
module code_sym_decode
    import code_sender_pkg::*;
(
    input  logic [1:0] sym,
    output logic       r,
    output logic       g,
    output logic       b
);

    // At most one colour is ever high
    always_comb begin
        {r, g, b} = sym_onehot(sym);
    end

endmodule

// File: rtl/code_sender.sv
// Colour-code transmitter: on Go, latches Code and sends one Start pulse then
// NUM_SYM colour pulses, each followed by GAP idle cycles, then pulses Done.
module code_sender
    import code_sender_pkg::*;
#(
    parameter int unsigned NUM_SYM = 4,
    parameter int unsigned GAP     = 2
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Go,
    input  logic                   Abort,
    input  logic [2*NUM_SYM-1:0]   Code,
    output logic                   S,
    output logic                   R,
    output logic                   G,
    output logic                   B,
    output logic                   Busy,
    output logic                   Done
);

    localparam int unsigned IDX_W    = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYM - 1);
    localparam logic [3:0]       GAP_LD   = 4'(GAP);

    logic [2:0]           state_q, state_d;
    logic [2*NUM_SYM-1:0] code_q, code_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [1:0]           sym_cur;
    logic                 dec_r, dec_g, dec_b;

    // State, latched code and counters
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; exit conditions are tested before counting so nothing wraps
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (Abort) begin
            // Abort also wins over Go while idle
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Go) begin
                        code_d  = Code;
                        idx_d   = '0;
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    if (GAP_LD == 4'd0) begin
                        state_d = ST_SYM;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LD;
                    end
                end
                ST_GAP: begin
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_SYM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_SYM: begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = (GAP_LD == 4'd0) ? ST_SYM : ST_GAP;
                        cnt_d   = GAP_LD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Select the symbol currently addressed by the index
    always_comb begin
        sym_cur = SYM_NONE;
        for (int i = 0; i < int'(NUM_SYM); i++) begin
            if (idx_q == IDX_W'(i)) begin
                sym_cur = code_q[2*i +: 2];
            end
        end
    end

    code_sym_decode u_dec (
        .sym (sym_cur),
        .r   (dec_r),
        .g   (dec_g),
        .b   (dec_b)
    );

    // Moore outputs decoded from registered state only; illegal states drive zeros
    always_comb begin
        S    = (state_q == ST_START);
        R    = (state_q == ST_SYM) && dec_r;
        G    = (state_q == ST_SYM) && dec_g;
        B    = (state_q == ST_SYM) && dec_b;
        Busy = (state_q == ST_START) || (state_q == ST_GAP) || (state_q == ST_SYM)
            || (state_q == ST_DONE);
        Done = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_code_sender.sv
// Directed bench for code_sender: a GAP=2 instance and a GAP=0 instance,
// outputs compared cycle by cycle against hand-written traces {S,R,G,B,Busy,Done}.
module tb_code_sender;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Go = 1'b0, Abort = 1'b0;
    logic [7:0] Code = 8'h00;
    logic       S, R, G, B, Busy, Done;
    logic       Go0 = 1'b0, Abort0 = 1'b0;
    logic [7:0] Code0 = 8'h00;
    logic       S0, R0, G0, B0, Busy0, Done0;
    logic [5:0] obs, obs0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] exp_nom [1:15];

    always #5 Clk = ~Clk;

    assign obs  = {S, R, G, B, Busy, Done};
    assign obs0 = {S0, R0, G0, B0, Busy0, Done0};

    code_sender #(.NUM_SYM(4), .GAP(2)) dut (
        .Clk(Clk), .Rst(Rst), .Go(Go), .Abort(Abort), .Code(Code),
        .S(S), .R(R), .G(G), .B(B), .Busy(Busy), .Done(Done)
    );

    code_sender #(.NUM_SYM(4), .GAP(0)) dut0 (
        .Clk(Clk), .Rst(Rst), .Go(Go0), .Abort(Abort0), .Code(Code0),
        .S(S0), .R(R0), .G(G0), .B(B0), .Busy(Busy0), .Done(Done0)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Go = 1'b1;
        Go0 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (obs !== 6'b000000) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %b want 000000", c, obs);
            end
            n_checks++;
            if (obs0 !== 6'b000000) begin
                n_fail++;
                $display("FAIL reset_hold_gap0 cycle %0d: got %b want 000000", c, obs0);
            end
        end
        Go0 = 1'b0;
        #2 Rst = 1'b1;
        tick();
        n_checks++;
        if (obs !== 6'b100010) begin
            n_fail++;
            $display("FAIL reset_first_go: got %b want 100010", obs);
        end
        Go = 1'b0;
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        n_checks++;
        if (obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_clear: got %b want 000000", obs);
        end
    endtask

    task automatic test_nominal();
        Code = 8'b01_10_11_01;
        Go = 1'b1;
        tick();
        Go = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 2) Code = 8'h00;  // must not disturb the frame in flight
            n_checks++;
            if (obs !== exp_nom[c]) begin
                n_fail++;
                $display("FAIL nominal cycle %0d: got %b want %b", c, obs, exp_nom[c]);
            end
            tick();
        end
    endtask

    task automatic test_gap0();
        logic [5:0] exp0 [1:7];
        exp0 = '{6'b100010, 6'b010010, 6'b001010, 6'b000110, 6'b000110, 6'b000011,
                 6'b000000};
        Code0 = 8'b11_11_10_01;
        Go0 = 1'b1;
        tick();
        Go0 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            n_checks++;
            if (obs0 !== exp0[c]) begin
                n_fail++;
                $display("FAIL gap0 cycle %0d: got %b want %b", c, obs0, exp0[c]);
            end
            tick();
        end
    endtask

    task automatic test_empty_slot();
        logic [5:0] exp_e [1:15];
        exp_e = exp_nom;
        exp_e[7] = 6'b000010;
        Code = 8'b01_10_00_01;
        Go = 1'b1;
        tick();
        Go = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            n_checks++;
            if (obs !== exp_e[c]) begin
                n_fail++;
                $display("FAIL empty_slot cycle %0d: got %b want %b", c, obs, exp_e[c]);
            end
            tick();
        end
    endtask

    task automatic test_abort();
        logic [5:0] exp_ff [1:15];
        exp_ff = '{6'b100010, 6'b000010, 6'b000010, 6'b000110, 6'b000010, 6'b000010,
                   6'b000110, 6'b000010, 6'b000010, 6'b000110, 6'b000010, 6'b000010,
                   6'b000110, 6'b000011, 6'b000000};
        Code = 8'b01_10_11_01;
        Go = 1'b1;
        tick();
        Go = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            n_checks++;
            if (obs !== exp_nom[c]) begin
                n_fail++;
                $display("FAIL abort_pre cycle %0d: got %b want %b", c, obs, exp_nom[c]);
            end
            if (c == 2) Code = 8'hFF;
            if (c == 8) Abort = 1'b1;
            tick();
        end
        Abort = 1'b0;
        for (int c = 9; c <= 10; c++) begin
            n_checks++;
            if (obs !== 6'b000000) begin
                n_fail++;
                $display("FAIL abort_idle cycle %0d: got %b want 000000", c, obs);
            end
            if (c == 10) Go = 1'b1;
            tick();
        end
        Go = 1'b0;
        for (int c = 11; c <= 25; c++) begin
            n_checks++;
            if (obs !== exp_ff[c-10]) begin
                n_fail++;
                $display("FAIL abort_restart cycle %0d: got %b want %b", c, obs, exp_ff[c-10]);
            end
            tick();
        end
        // Go together with Abort while idle must not start a frame
        Go = 1'b1;
        Abort = 1'b1;
        tick();
        Go = 1'b0;
        Abort = 1'b0;
        n_checks++;
        if (obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL abort_over_go: got %b want 000000", obs);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_bb [1:31];
        for (int c = 1; c <= 15; c++) exp_bb[c] = exp_nom[c];
        for (int c = 16; c <= 29; c++) exp_bb[c] = 6'b000010;
        exp_bb[16] = 6'b100010;
        exp_bb[19] = 6'b000110;
        exp_bb[22] = 6'b001010;
        exp_bb[25] = 6'b010010;
        exp_bb[29] = 6'b000011;
        exp_bb[30] = 6'b000000;
        exp_bb[31] = 6'b100010;
        Code = 8'b01_10_11_01;
        Go = 1'b1;
        tick();
        for (int c = 1; c <= 31; c++) begin
            Code = (c == 15) ? 8'b00_01_10_11 : c[7:0];
            n_checks++;
            if (obs !== exp_bb[c]) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %b want %b", c, obs, exp_bb[c]);
            end
            tick();
        end
        Go = 1'b0;
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
    endtask

    task automatic test_async_reset();
        Code = 8'b01_10_11_01;
        Go = 1'b1;
        tick();
        Go = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if (obs !== 6'b010010) begin
            n_fail++;
            $display("FAIL async_pre: got %b want 010010", obs);
        end
        #2 Rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %b want 000000", obs);
        end
        tick();
        #2 Rst = 1'b1;
        tick();
        n_checks++;
        if (obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL async_reset_after: got %b want 000000", obs);
        end
    endtask

    initial begin
        exp_nom = '{6'b100010, 6'b000010, 6'b000010, 6'b010010, 6'b000010, 6'b000010,
                    6'b000110, 6'b000010, 6'b000010, 6'b001010, 6'b000010, 6'b000010,
                    6'b010010, 6'b000011, 6'b000000};
        #1;
        test_reset();
        test_nominal();
        test_gap0();
        test_empty_slot();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
